conv_result_requant: RTL

Downstream stage of the 4x4 tile convolution engine. On `start` it snapshots the engine's sixteen 16-bit results, so the engine can begin its next tile. It then applies a per-tile bias, optional ReLU, a rounding right shift and signed-8-bit saturation to each result. The int8 results leave in raster order over a valid/ready byte stream towards the activation buffer.

---
 rtl/conv_result_requant.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/conv_result_requant.sv
// Snapshots a tile of unsigned convolution results and streams them out in raster order
// as saturated int8 values after bias, optional ReLU and a rounding right shift.
module conv_result_requant #(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int IN_W    = 16,
    parameter int OUT_W   = 8,
    parameter int SHIFT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [IN_W-1:0]    c_in [0:ROWS-1][0:COLS-1],
    input  logic [17:0]        bias,
    input  logic [SHIFT_W-1:0] shift,
    input  logic               relu_en,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               busy,
    output logic               done
);

    localparam int N      = ROWS * COLS;
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int ACC_W  = 19;
    localparam int BIAS_W = 18;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    localparam logic IDLE   = 1'b0;
    localparam logic STREAM = 1'b1;

    function automatic logic signed [ACC_W-1:0] round_shift(
        input logic signed [ACC_W-1:0] s,
        input logic [SHIFT_W-1:0]      sh
    );
        logic signed [ACC_W-1:0] half;
        if (sh == '0) begin
            return s;
        end
        half = ACC_W'(1) << (sh - SHIFT_W'(1));
        return (s + half) >>> sh;
    endfunction

    function automatic logic signed [OUT_W-1:0] saturate(input logic signed [ACC_W-1:0] s);
        if (s > SAT_MAX) begin
            return SAT_MAX[OUT_W-1:0];
        end
        if (s < SAT_MIN) begin
            return SAT_MIN[OUT_W-1:0];
        end
        return s[OUT_W-1:0];
    endfunction

    function automatic logic signed [OUT_W-1:0] requant(
        input logic [IN_W-1:0]          c,
        input logic signed [BIAS_W-1:0] b,
        input logic [SHIFT_W-1:0]       sh,
        input logic                     relu
    );
        logic signed [ACC_W-1:0] s;
        s = $signed({{(ACC_W - IN_W){1'b0}}, c}) + $signed({{(ACC_W - BIAS_W){b[BIAS_W-1]}}, b});
        if (relu && s < 0) begin
            s = '0;
        end
        return saturate(round_shift(s, sh));
    endfunction

    logic                     state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d, idx_nxt;
    logic signed [OUT_W-1:0]  out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_last_q, out_last_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic signed [BIAS_W-1:0] bias_q, bias_d;
    logic [SHIFT_W-1:0]       shift_q, shift_d;
    logic                     relu_q, relu_d;
    logic                     load_tile;
    logic [IN_W-1:0]          tile_q [0:N-1];

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        bias_d      = bias_q;
        shift_d     = shift_q;
        relu_d      = relu_q;
        load_tile   = 1'b0;
        idx_nxt     = idx_q + IDX_W'(1);
        case (state_q)
            IDLE: begin
                out_valid_d = 1'b0;
                if (start) begin
                    load_tile   = 1'b1;
                    bias_d      = $signed(bias);
                    shift_d     = shift;
                    relu_d      = relu_en;
                    // Element (0,0) bypasses the buffer so it can be presented on the next cycle.
                    out_data_d  = requant(c_in[0][0], $signed(bias), shift, relu_en);
                    idx_d       = '0;
                    out_valid_d = 1'b1;
                    out_last_d  = (N == 1);
                    busy_d      = 1'b1;
                    state_d     = STREAM;
                end
            end
            default: begin
                if (out_valid_q && out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        idx_d      = idx_nxt;
                        out_data_d = requant(tile_q[idx_nxt], bias_q, shift_q, relu_q);
                        out_last_d = (idx_nxt == LAST_IDX);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bias_q      <= '0;
            shift_q     <= '0;
            relu_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            bias_q      <= bias_d;
            shift_q     <= shift_d;
            relu_q      <= relu_d;
        end
    end

    // Tile snapshot, flattened in raster order; holds data only, so it needs no reset.
    for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
        for (genvar gc = 0; gc < COLS; gc++) begin : g_col
            always_ff @(posedge clk) begin
                if (load_tile) begin
                    tile_q[gr*COLS + gc] <= c_in[gr][gc];
                end
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
